reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset conditioner for the iCEBreaker LED panel top level. It synchronises and debounces the raw push-button and accepts a software reset pulse, such as a decoded UART command. It holds all reset outputs for a programmable delay, then releases N_OUT reset domains one at a time with a fixed gap. It sits between board pins and every functional core, including the panel driver and UART receiver.

## Interface
- DELAY_BIT, 15, hold time is 2^DELAY_BIT cycles after the last trigger clears
- N_OUT, 2, number of staged reset outputs, ≥1
- GAP_BIT, 4, 2^GAP_BIT cycles between consecutive channel releases
- DEBOUNCE_BIT, 10, button level must be stable 2^DEBOUNCE_BIT cycles to be accepted
- WDT_BIT, 20, watchdog timeout 2^WDT_BIT cycles (used only with macro)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high master reset
- btn_n  in  1  raw button, asynchronous, active-low
- sw_req  in  1  synchronous single-cycle software reset request
- wdt_kick  in  1  synchronous watchdog kick; ignored without macro
- rst_out  out  N_OUT  active-high domain resets; bit i released i-th
- ready  out  1  high once all domains are released
- cause  out  2  last trigger: 0 master reset, 1 button, 2 software, 3 watchdog

## Operation
- Async reset values: state HOLD, all counters 0, rst_out all 1, ready 0, cause 0, synchroniser flops 1, debounced button = released.
- btn_n passes through a 2-flop synchroniser. The debounced level changes only after the synchronised level differs from it for 2^DEBOUNCE_BIT consecutive cycles. Any bounce restarts the count.
- trigger = debounced pressed (level) OR sw_req OR watchdog expiry.
- FSM:
  - HOLD: rst_out all 1, ready 0. Delay counter (DELAY_BIT+1 bits) clears while trigger is high and increments otherwise. When it reaches 2^DELAY_BIT: rst_out[0] ← 0, idx ← 1, gap counter ← 0. Go to STAGE, or to RUN if N_OUT=1.
  - STAGE: gap counter increments. On reaching 2^GAP_BIT: rst_out[idx] ← 0, gap ← 0, idx++. After the last channel, go to RUN.
  - RUN: ready 1, all rst_out 0.
- Trigger in any state: the next edge enters HOLD, sets all rst_out to 1, sets ready to 0, clears the delay counter, and updates cause.
- A button held down keeps the block in HOLD indefinitely. The delay starts after the debounced release.
- Simultaneous triggers set cause by priority: button > software > watchdog.
- Release order is monotonic: rst_out[i] never deasserts before rst_out[i-1].

## Timing
- No triggers after reset deasserts:
  - rst_out[0] falls on rising edge 2^DELAY_BIT.
  - rst_out[i] falls on edge 2^DELAY_BIT + i·2^GAP_BIT.
  - ready rises on the same edge as rst_out[N_OUT-1] falls.
- sw_req high at edge k: rst_out reasserts at edge k. Counting starts at k+1, so rst_out[0] falls at edge k+2^DELAY_BIT.
- Button press to reassert: 2 sync cycles + 2^DEBOUNCE_BIT cycles + 1.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- RESET_SEQ_WATCHDOG_EN defined:
  - A WDT_BIT+1-bit counter runs only in RUN and clears on wdt_kick.
  - Reaching 2^WDT_BIT raises a trigger with cause 3.
  - The counter is held at 0 outside RUN.
- Not defined: no watchdog logic, wdt_kick unused, cause is never 3.

## Structure
- Package reset_seq_pkg holds:
  - the state enum typedef (HOLD, STAGE, RUN)
  - cause localparams CAUSE_POR, CAUSE_BTN, CAUSE_SW, CAUSE_WDT
- Sub-module btn_debounce: synchroniser plus debounce counter, parameter DEBOUNCE_BIT, output pressed level.

## Test plan
All cases use DELAY_BIT=4, GAP_BIT=2, N_OUT=3, DEBOUNCE_BIT=3, WDT_BIT=5.
- Power-up: release reset, no triggers → rst_out 111 until edge 16, then 110, 100 at 20, 000 at 24; ready=1 at 24; cause=0.
- Software reset: in RUN, pulse sw_req at edge k → rst_out=111, ready=0 at k; rst_out[0] falls at k+16; cause=2.
- Bounced button: toggle btn_n every 3 cycles for 40 cycles → no reset. Then hold it low 8+ cycles → reset within 2+8+1 cycles, cause=1. Hold 100 cycles → rst_out stays 111 until 16 edges after debounced release.
- Mid-sequence trigger: sw_req at edge 21 (after rst_out[1] released) → rst_out back to 111 at 21, full sequence restarts.
- Simultaneous sw_req and debounced press → cause=1.
- Macro defined: no kick for 32 cycles in RUN → HOLD, cause=3. With a kick every 20 cycles, no reset over 500 cycles. Macro undefined: no reset with zero kicks.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
//   state_t        : sequencer FSM states (HOLD, STAGE, RUN)
//   CAUSE_*        : encodings reported on the 'cause' output
//   trigger_cause  : priority encoder for simultaneous triggers
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  // Only meaningful while some trigger is active: button beats software,
  // software beats watchdog, so the watchdog is the fall-through case.
  function automatic logic [1:0] trigger_cause(input logic btn, input logic sw);
    if (btn) return CAUSE_BTN;
    if (sw)  return CAUSE_SW;
    return CAUSE_WDT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a debouncer.
// The debounced level follows the synchronised level only after the two
// have differed for 2^DEBOUNCE_BIT consecutive cycles; any bounce back
// restarts the count.
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   btn_n   in  raw asynchronous button, active-low
//   pressed out debounced button level, 1 = pressed
module btn_debounce #(
  parameter int DEBOUNCE_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed
);

  logic                    sync_1;
  logic                    sync_2;
  logic                    level;   // debounced copy of btn_n, 1 = released
  logic [DEBOUNCE_BIT-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the synchroniser stages do not collapse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        // This edge completes 2^DEBOUNCE_BIT differing cycles.
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/reset_sequencer.sv
// Reset conditioner for the LED panel top level. Any trigger (debounced
// button held, software pulse, optional watchdog expiry) forces all domain
// resets high; once triggers clear, all outputs are held for 2^DELAY_BIT
// cycles, then rst_out[0..N_OUT-1] are released in order with a gap of
// 2^GAP_BIT cycles between channels.
// Optional feature: define RESET_SEQ_WATCHDOG_EN to add a watchdog that
// counts in RUN, clears on wdt_kick and triggers (cause 3) at 2^WDT_BIT.
//   clk      in  system clock
//   reset    in  asynchronous active-high master reset
//   btn_n    in  raw asynchronous button, active-low
//   sw_req   in  single-cycle software reset request
//   wdt_kick in  watchdog kick (unused without the watchdog)
//   rst_out  out active-high domain resets, bit i released i-th
//   ready    out high once every domain is released
//   cause    out last trigger: 0 master, 1 button, 2 software, 3 watchdog
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DELAY_BIT    = 15,
  parameter int N_OUT        = 2,
  parameter int GAP_BIT      = 4,
  parameter int DEBOUNCE_BIT = 10,
  parameter int WDT_BIT      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_n,
  input  logic             sw_req,
  input  logic             wdt_kick,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic [1:0]       cause
);

  // Terminal values one below 2^N: the edge that steps past them is the
  // edge on which the counter reaches 2^N and a channel is released.
  localparam logic [DELAY_BIT:0] DELAY_LAST = {1'b0, {DELAY_BIT{1'b1}}};
  localparam logic [GAP_BIT:0]   GAP_LAST   = {1'b0, {GAP_BIT{1'b1}}};

  state_t             state_q, state_d;
  logic [DELAY_BIT:0] dly_q, dly_d;
  logic [GAP_BIT:0]   gap_q, gap_d;
  logic [N_OUT-1:0]   rst_out_d;
  logic               ready_d;
  logic [1:0]         cause_d;
  logic [N_OUT-1:0]   released;
  logic               pressed;
  logic               wdt_expire;
  logic               trigger;

  btn_debounce #(
    .DEBOUNCE_BIT(DEBOUNCE_BIT)
  ) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_n  (btn_n),
    .pressed(pressed)
  );

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [WDT_BIT:0] wdt_cnt;

  // Counter value 2^WDT_BIT is the only one with the top bit set.
  assign wdt_expire = wdt_cnt[WDT_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if (state_q != RUN || wdt_kick || wdt_expire) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_wdt;

  assign wdt_expire = 1'b0;
  assign unused_wdt = {31'd0, wdt_kick} ^ 32'(WDT_BIT);
`endif

  assign trigger  = pressed | sw_req | wdt_expire;
  // Channels release from bit 0 upward, so shifting in a zero is the next
  // release step and keeps the order monotonic by construction.
  assign released = rst_out << 1;

  // NOTE: every signal written here gets its default first so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    gap_d     = gap_q;
    rst_out_d = rst_out;
    ready_d   = ready;
    cause_d   = cause;
    if (trigger) begin
      state_d   = HOLD;
      dly_d     = '0;
      gap_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      cause_d   = trigger_cause(pressed, sw_req);
    end else begin
      unique case (state_q)
        HOLD: begin
          dly_d = dly_q + 1'b1;
          if (dly_q == DELAY_LAST) begin
            rst_out_d = released;
            gap_d     = '0;
            if (released == '0) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = STAGE;
            end
          end
        end
        STAGE: begin
          if (gap_q == GAP_LAST) begin
            rst_out_d = released;
            gap_d     = '0;
            if (released == '0) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      dly_q   <= '0;
      gap_q   <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      gap_q   <= gap_d;
      rst_out <= rst_out_d;
      ready   <= ready_d;
      cause   <= cause_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with DELAY_BIT=4, GAP_BIT=2, N_OUT=3,
// DEBOUNCE_BIT=3, WDT_BIT=5. Edge numbers count rising clock edges after
// master reset deasserts; outputs are sampled 1 time unit after each edge.
module tb_reset_sequencer;

  localparam int DELAY_BIT    = 4;
  localparam int N_OUT        = 3;
  localparam int GAP_BIT      = 2;
  localparam int DEBOUNCE_BIT = 3;
  localparam int WDT_BIT      = 5;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             btn_n    = 1'b1;
  logic             sw_req   = 1'b0;
  logic             wdt_kick = 1'b0;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic [1:0]       cause;

  int   tests = 0;
  int   fails = 0;
  int   e     = 0;
  int   glitch;
  logic kick_en    = 1'b1;
  logic force_kick = 1'b0;
  int   kick_div   = 0;

  reset_sequencer #(
    .DELAY_BIT   (DELAY_BIT),
    .N_OUT       (N_OUT),
    .GAP_BIT     (GAP_BIT),
    .DEBOUNCE_BIT(DEBOUNCE_BIT),
    .WDT_BIT     (WDT_BIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .sw_req  (sw_req),
    .wdt_kick(wdt_kick),
    .rst_out (rst_out),
    .ready   (ready),
    .cause   (cause)
  );

  always #5 clk = ~clk;

  // Background kicker: one kick every 20 cycles while enabled, or a single
  // kick on request; ignored by the design when the watchdog is absent.
  initial begin
    forever begin
      @(negedge clk);
      if (force_kick) begin
        wdt_kick = 1'b1;
      end else if (kick_en) begin
        if (kick_div == 19) begin
          kick_div = 0;
          wdt_kick = 1'b1;
        end else begin
          kick_div++;
          wdt_kick = 1'b0;
        end
      end else begin
        wdt_kick = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic go_to(input int target);
    while (e < target) step();
  endtask

  // Advance to 'target' counting edges on which any domain was in reset.
  task automatic quiet_until(input int target, output int hits);
    hits = 0;
    while (e < target) begin
      step();
      if (rst_out !== '0) hits++;
    end
  endtask

  task automatic sw_pulse();
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_rst_out", 32'(rst_out), 32'h7);
    check("reset_ready",   32'(ready),   32'h0);
    check("reset_cause",   32'(cause),   32'h0);

    // Power-up release schedule: 16, 20, 24.
    go_to(15); check("pu_e15_rst", 32'(rst_out), 32'h7);
    go_to(16); check("pu_e16_rst", 32'(rst_out), 32'h6);
               check("pu_e16_rdy", 32'(ready),   32'h0);
    go_to(19); check("pu_e19_rst", 32'(rst_out), 32'h6);
    go_to(20); check("pu_e20_rst", 32'(rst_out), 32'h4);
    go_to(23); check("pu_e23_rdy", 32'(ready),   32'h0);
    go_to(24); check("pu_e24_rst", 32'(rst_out), 32'h0);
               check("pu_e24_rdy", 32'(ready),   32'h1);
               check("pu_cause",   32'(cause),   32'h0);

    // Software reset in RUN at edge 31.
    go_to(30); sw_pulse();
    check("sw_k_rst",   32'(rst_out), 32'h7);
    check("sw_k_rdy",   32'(ready),   32'h0);
    check("sw_k_cause", 32'(cause),   32'h2);
    go_to(46); check("sw_k15_rst", 32'(rst_out), 32'h7);
    go_to(47); check("sw_k16_rst", 32'(rst_out), 32'h6);
    go_to(55); check("sw_done_rst", 32'(rst_out), 32'h0);
               check("sw_done_rdy", 32'(ready),   32'h1);

    // Restart at k+21 after channel 1 has been released.
    go_to(59); sw_pulse();                               // k = 60
    go_to(80); check("mid_k20_rst", 32'(rst_out), 32'h4);
    sw_pulse();                                          // edge 81
    check("mid_k21_rst", 32'(rst_out), 32'h7);
    check("mid_k21_rdy", 32'(ready),   32'h0);
    go_to(96);  check("mid_r15_rst", 32'(rst_out), 32'h7);
    go_to(97);  check("mid_r16_rst", 32'(rst_out), 32'h6);
    go_to(101); check("mid_r20_rst", 32'(rst_out), 32'h4);
    go_to(105); check("mid_r24_rst", 32'(rst_out), 32'h0);
                check("mid_r24_rdy", 32'(ready),   32'h1);

    // Bouncing button never settles long enough to be accepted.
    go_to(110);
    glitch = 0;
    for (int i = 0; i < 14; i++) begin
      btn_n = ~btn_n;
      for (int j = 0; j < 3; j++) begin
        step();
        if (rst_out !== '0) glitch++;
      end
    end
    for (int j = 0; j < 10; j++) begin
      step();
      if (rst_out !== '0) glitch++;
    end
    check("bounce_no_reset", 32'(glitch), 32'h0);
    check("bounce_ready",    32'(ready),  32'h1);

    // Clean press after edge 162: reasserts at 162 + 2 + 8 + 1 = 173.
    btn_n = 1'b0;
    go_to(172); check("btn_e172_rst", 32'(rst_out), 32'h0);
    go_to(173); check("btn_e173_rst", 32'(rst_out), 32'h7);
                check("btn_cause",    32'(cause),   32'h1);
    go_to(262); check("btn_held_rst", 32'(rst_out), 32'h7);
    btn_n = 1'b1;                     // debounced release lands on edge 272
    go_to(287); check("btn_rel15_rst", 32'(rst_out), 32'h7);
    go_to(288); check("btn_rel16_rst", 32'(rst_out), 32'h6);
    go_to(296); check("btn_done_rdy",  32'(ready),   32'h1);

    // Software pulse coinciding with the debounced press: button wins.
    go_to(300); btn_n = 1'b0;         // debounced press on edge 310
    go_to(310); check("sim_pre_rst", 32'(rst_out), 32'h0);
    sw_pulse();                       // edge 311 sees both triggers
    check("sim_rst",   32'(rst_out), 32'h7);
    check("sim_cause", 32'(cause),   32'h1);
    btn_n = 1'b1;                     // debounced release on edge 321
    go_to(336); check("sim_rel15_rst", 32'(rst_out), 32'h7);
    go_to(345); check("sim_done_rst",  32'(rst_out), 32'h0);
                check("sim_done_rdy",  32'(ready),   32'h1);

`ifdef RESET_SEQ_WATCHDOG_EN
    // Last kick at edge 351; counter reaches 32 at 383, trigger at 384.
    go_to(350);
    kick_en    = 1'b0;
    force_kick = 1'b1;
    step();
    force_kick = 1'b0;
    go_to(383); check("wdt_e383_rst", 32'(rst_out), 32'h0);
    go_to(384); check("wdt_e384_rst", 32'(rst_out), 32'h7);
                check("wdt_cause",    32'(cause),   32'h3);
                check("wdt_rdy",      32'(ready),   32'h0);
    kick_en = 1'b1;
    go_to(408); check("wdt_rerun_rdy", 32'(ready), 32'h1);
    quiet_until(908, glitch);
    check("wdt_kicked_quiet", 32'(glitch), 32'h0);
    check("wdt_kicked_cause", 32'(cause),  32'h3);
`else
    go_to(350);
    kick_en = 1'b0;
    quiet_until(450, glitch);
    check("nowdt_quiet", 32'(glitch), 32'h0);
    check("nowdt_rdy",   32'(ready),  32'h1);
    check("nowdt_cause", 32'(cause),  32'h1);
`endif

    // Master reset acts asynchronously, mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(rst_out), 32'h7);
    check("async_ready",   32'(ready),   32'h0);
    check("async_cause",   32'(cause),   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
